// File: rtl/chan_mux_seq_if.sv
// Output sample stream of chan_mux_seq: data, channel tag and valid/ready.
// The master drives the sample and valid, the slave returns ready.
interface chan_mux_seq_if #(
  parameter int W    = 8,
  parameter int SELW = 3
);
  logic [W-1:0]    dout;
  logic [SELW-1:0] dout_ch;
  logic            dout_valid;
  logic            dout_ready;

  modport master (
    output dout,
    output dout_ch,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_ch,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/chan_mux_seq.sv
// Registered N-channel mux with manual select or dwell-gapped auto-scan.
// Define CHAN_MASK_EN to add the ch_mask input for skipping channels.
module chan_mux_seq #(
  parameter int NCH   = 8,
  parameter int W     = 8,
  parameter int SELW  = 3,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH*W-1:0] din,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            enable,
`ifdef CHAN_MASK_EN
  input  logic [NCH-1:0]  ch_mask,
`endif
  chan_mux_seq_if.master  bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'((DWELL > 0) ? DWELL - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WAIT,
    DWELL_ST
  } state_t;

  state_t          state_q;
  logic [SELW-1:0] ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    dout_q;
  logic [SELW-1:0] ch_q;
  logic            valid_q;

  logic [NCH-1:0]  ch_en;
  logic            any_en;
  logic [SELW-1:0] cap_ch;
  logic [W-1:0]    cap_dat;
  logic [SELW-1:0] ptr_adv;
  logic            accept;

`ifdef CHAN_MASK_EN
  assign ch_en = ch_mask;
`else
  assign ch_en = '1;
`endif

  assign any_en = |ch_en;
  assign accept = valid_q && bus.dout_ready;
  assign cap_ch = mode ? ptr_q : sel;

  // Out-of-range or masked channels read as zero.
  always_comb begin
    cap_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cap_ch == SELW'(k) && ch_en[k]) begin
        cap_dat = din[k*W +: W];
      end
    end
  end

  // Next enabled channel above ptr, wrapping.
  always_comb begin
    logic found;
    int   idx;
    ptr_adv = ptr_q;
    found   = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(ptr_q) + i) % NCH;
      if (!found && ch_en[idx]) begin
        ptr_adv = SELW'(idx);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (enable && (!mode || any_en)) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          dout_q  <= cap_dat;
          ch_q    <= cap_ch;
          valid_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (accept) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            if (!enable) begin
              state_q <= IDLE;
            end else if (!mode) begin
              state_q <= CAPTURE;
            end else if (DWELL == 0 && any_en) begin
              ptr_q   <= ptr_adv;
              state_q <= CAPTURE;
            end else begin
              state_q <= DWELL_ST;
            end
          end
        end
        DWELL_ST: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            // Park at terminal count while no channel is enabled.
            if (any_en) begin
              ptr_q   <= ptr_adv;
              cnt_q   <= '0;
              state_q <= CAPTURE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_ch    = ch_q;
  assign bus.dout_valid = valid_q;

endmodule
